switch_debounce_bank: RTL and testbench
=======================================

Name: switch_debounce_bank

Overview:
Upstream conditioning stage for the 10-switch input group.
- Synchronises raw switch/button levels to clk.
- Filters contact bounce per channel with a shared millisecond-scale tick.
- Presents clean, stable levels on db_out, which feeds the positive-edge detector stage.
- Also exports an all-ones flag.

Parameters:
WIDTH, 10, number of independent input channels
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); legal range >= 2
STABLE_TICKS, 20, consecutive ticks a new level must persist before db_out changes; legal range >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
raw_in  input  WIDTH  asynchronous raw switch/button levels
db_out  output  WIDTH  debounced, registered levels
db_all  output  1  AND-reduction of db_out, combinational from db_out registers
tick  output  1  one-cycle sample strobe, for debug and bench synchronisation

Behaviour:
Reset and clocking
- Reset: clk is the only clock. rst is asynchronous, active-high, and clears all state.
- Values during and after reset: sync stages = 0, prescaler = 0, channel counters = 0, db_out = 0, db_all = 0, tick = 0.
- Reset mid-debounce: discards partial counts. db_out returns to 0 immediately and re-qualifies from scratch after release.

Synchroniser
- Two-flop synchroniser per bit: raw_in -> s1 -> s2.
- s2 is the only value the filter logic uses.

Prescaler
- Counter runs 0..TICK_DIV-1 and wraps to 0.
- tick = 1 for exactly the cycle in which the counter equals TICK_DIV-1.
- First tick after reset release occurs on cycle TICK_DIV.

Per-channel filter (channel i), with a counter of width clog2(STABLE_TICKS+1)
- s2[i] == db_out[i]: cnt <= 0. A glitch shorter than the qualification window leaves no residue.
- s2[i] != db_out[i] and tick = 0: cnt holds.
- s2[i] != db_out[i], tick = 1, cnt < STABLE_TICKS-1: cnt <= cnt+1.
- s2[i] != db_out[i], tick = 1, cnt == STABLE_TICKS-1: db_out[i] <= s2[i] and cnt <= 0 in the same edge.
- With STABLE_TICKS = 1, the first tick with a mismatch updates db_out.

Latency
- Clean raw step to db_out change is 2 (sync) plus between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles.
- The range depends on prescaler phase.

Boundary conditions
- Mismatch arriving in the same cycle as tick: counts that tick.
- Bounce (any return to match) before qualification: cnt cleared. db_out never changes and never pulses.
- Channels are fully independent. Simultaneous qualification on several channels updates all of them on the same edge.
- db_out changes at most once per tick period per channel.

Output guarantee
- db_out is glitch-free and registered.
- db_all has no combinational path from raw_in.

Decomposition:
- Shared package holds:
  - Default constants DEB_WIDTH = 10, DEB_TICK_DIV = 100000, DEB_STABLE_TICKS = 20.
  - Function clog2 for counter sizing.
- One sub-module, debounce_channel (1-bit synchroniser + counter + output register). It is instantiated WIDTH times by a generate loop.
- Prescaler and db_all stay in the top.

Test Plan:
Bench parameters for all scenarios: WIDTH = 10, TICK_DIV = 4, STABLE_TICKS = 3.
1. Reset: assert rst asynchronously mid-cycle with raw_in = 10'h3FF -> db_out = 0, db_all = 0, tick = 0 immediately. After release, first tick on cycle 4, then every 4 cycles.
2. Clean step: raw_in 0 -> 10'h3FF held -> db_out = 10'h3FF and db_all = 1 after 11..14 cycles. Never earlier, and all bits change on the same edge.
3. Bounce: raw_in[0] toggles 1/0 every 3 cycles for 40 cycles -> db_out[0] stays 0. After raw_in[0] is held at 1, db_out[0] = 1 within 14 cycles.
4. Mismatch coincident with tick: change raw_in[5] so that s2[5] first differs on a tick cycle -> db_out[5] updates exactly 2 ticks later (8 cycles after that tick).
5. Reset mid-qualification: raw_in = 10'h001 held, pulse rst after the 2nd counted tick -> db_out[0] = 0. Full 3-tick requalification is required after release.
6. Release path: from db_out = 10'h3FF, drop raw_in[9] -> db_out = 10'h1FF and db_all falls to 0 on the same edge. Other bits are unaffected.

Source files
------------

// File: rtl/switch_debounce_bank_pkg.sv
// Shared constants and sizing helper for the switch debounce bank.
package switch_debounce_bank_pkg;

  localparam int DEB_WIDTH        = 10;
  localparam int DEB_TICK_DIV     = 100000;
  localparam int DEB_STABLE_TICKS = 20;

  // Bits needed to represent values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/switch_debounce_bank_channel.sv
// One debounce lane: two-flop synchroniser, tick-qualified stability counter
// and the registered clean level.
module debounce_channel
  import switch_debounce_bank_pkg::*;
#(
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_db
);

  localparam int            CW       = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any return to the current level wipes progress, so short glitches leave no residue.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == LAST_CNT) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/switch_debounce_bank.sv
// Debounce bank for the switch input group: shared sample-tick prescaler,
// one debounce lane per input and an all-ones flag.
module switch_debounce_bank
  import switch_debounce_bank_pkg::*;
#(
  parameter int WIDTH        = DEB_WIDTH,
  parameter int TICK_DIV     = DEB_TICK_DIV,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic             db_all,
  output logic             tick
);

  localparam int            PW         = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign tick = w_tick;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      debounce_channel #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .i_raw (raw_in[gi]),
        .i_tick(w_tick),
        .o_db  (db_out[gi])
      );
    end
  endgenerate

  // Decoded only from the lane output registers, never from raw_in.
  assign db_all = &db_out;

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Randomised and directed bench for switch_debounce_bank against a
// mismatch-interval reference model.
module tb_switch_debounce_bank;

  localparam int W  = 10;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic         db_all;
  logic         tick;

  always #5 clk = ~clk;

  switch_debounce_bank #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
    .db_out(db_out),
    .db_all(db_all),
    .tick  (tick)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: cycle index since reset release, expected
  // outputs, cycle at which each lane's current mismatch began (-1 = none),
  // and the raw values of the previous two cycles.
  int           c;
  logic [W-1:0] mdb;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] cur;
  int           start [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  // Number of tick cycles (k mod TD == TD-1) in the inclusive range [a, b].
  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / TD - a / TD;
  endfunction

  task automatic model_reset();
    c   = 0;
    mdb = '0;
    d1  = '0;
    d2  = '0;
    for (int i = 0; i < W; i++) start[i] = -1;
  endtask

  // Called #1 after an edge: drive this cycle's raw value, compare outputs,
  // advance the model across the next edge.
  task automatic step(input logic [W-1:0] v);
    logic [W-1:0] s2;
    logic [W-1:0] nxt;
    bit           tk;
    raw_in = v;
    cur    = v;
    tk     = ((c % TD) == TD - 1);
    check("tick", 32'(tick), 32'(tk));
    check("db_out", 32'(db_out), 32'(mdb));
    check("db_all", 32'(db_all), 32'(&mdb));
    s2  = d2;
    nxt = mdb;
    for (int i = 0; i < W; i++) begin
      if (s2[i] == mdb[i]) begin
        start[i] = -1;
      end else begin
        if (start[i] < 0) start[i] = c;
        if (tk && ticks_in(start[i], c) == ST) begin
          nxt[i]   = s2[i];
          start[i] = -1;
        end
      end
    end
    mdb = nxt;
    d2  = d1;
    d1  = v;
    @(posedge clk);
    #1;
    c++;
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_db_out", 32'(db_out), 32'd0);
    check("rst_db_all", 32'(db_all), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lat;
    int tc;
    int t1;
    logic [W-1:0] v;

    rst    = 1'b1;
    raw_in = '0;
    cur    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (6) step('0);

    // Reset with all inputs high, then tick cadence after release.
    raw_in = 10'h3FF;
    cur    = 10'h3FF;
    do_reset();
    repeat (16 + $urandom_range(3)) step('0);

    // Clean step on all lanes; latency must fall inside the phase window.
    c0  = c;
    lat = 99;
    step(10'h3FF);
    for (int k = 0; k < 20; k++) begin
      if (db_out == 10'h3FF && lat == 99) lat = c - c0;
      step(10'h3FF);
    end
    check("step_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);

    // Release one lane; db_all must fall with it.
    for (int k = 0; k < 20; k++) step(10'h1FF);
    check("release_db_out", 32'(db_out), 32'h1FF);
    check("release_db_all", 32'(db_all), 32'd0);

    // Bounce on lane 0 never qualifies; a steady level then does.
    repeat (20) step('0);
    for (int k = 0; k < 40; k++) step(((k / 3) % 2 == 0) ? 10'h001 : 10'h000);
    check("bounce_db0", 32'(db_out[0]), 32'd0);
    c0  = c;
    lat = 99;
    step(10'h001);
    for (int k = 0; k < 20; k++) begin
      if (db_out[0] && lat == 99) lat = c - c0;
      step(10'h001);
    end
    check("bounce_settle_within_14", 32'(lat <= 14), 32'd1);

    // Lane 5 mismatch first seen at the synchroniser output on a tick cycle.
    while (((c + 2) % TD) != TD - 1) step(cur);
    tc = c + 2;
    step(cur | 10'h020);
    while (c < tc + 8) step(cur);
    check("coinc_before_edge", 32'(db_out[5]), 32'd0);
    step(cur);
    check("coinc_after_edge", 32'(db_out[5]), 32'd1);

    // Reset after the second counted tick discards progress on lane 0.
    repeat (20) step('0);
    c0 = c;
    step(10'h001);
    t1 = c0 + 2;
    while ((t1 % TD) != TD - 1) t1++;
    while (c <= t1 + TD) step(cur);
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (c == ST * TD - 1) check("requal_not_yet", 32'(db_out[0]), 32'd0);
      if (c == ST * TD) check("requal_done", 32'(db_out[0]), 32'd1);
      step(cur);
    end

    // Random flips per lane with occasional asynchronous resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(199) == 0) do_reset();
      v = cur;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(15) == 0) v[i] = ~v[i];
      end
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
